// File: rtl/obs_split_sequencer_97bit.sv
// obs_split_sequencer_97bit: splits 193-bit GF(2) operands into even/odd halves and issues four 97-bit sub-product requests
module obs_split_sequencer_97bit #(
    parameter int N = 193
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       a_in,
    input  logic [N-1:0]       b_in,
    output logic               sub_valid,
    input  logic               sub_ready,
    output logic [1:0]         sub_idx,
    output logic [(N+1)/2-1:0] sub_a,
    output logic [(N+1)/2-1:0] sub_b,
    output logic               sub_last,
    output logic               busy
);
    localparam int H = (N + 1) / 2;
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state_q, state_d;
    logic [1:0] idx_q, idx_d, sub_idx_q, sub_idx_d;
    logic sub_last_q, sub_last_d;
    logic [H-1:0] ae_q, ae_d, ao_q, ao_d, be_q, be_d, bo_q, bo_d;
    logic [H-1:0] sub_a_q, sub_a_d, sub_b_q, sub_b_d;
    logic [H-1:0] a_e, a_o, b_e, b_o;
    always_comb begin
        a_e = '0;
        a_o = '0;
        b_e = '0;
        b_o = '0;
        for (int k = 0; k < H; k++) begin
            a_e[k] = a_in[2*k];
            b_e[k] = b_in[2*k];
        end
        for (int k = 0; k < H - 1; k++) begin
            a_o[k] = a_in[2*k+1];
            b_o[k] = b_in[2*k+1];
        end
    end
    // payload lives in its own registers so it keeps the last request after idx wraps
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ae_d       = ae_q;
        ao_d       = ao_q;
        be_d       = be_q;
        bo_d       = bo_q;
        sub_a_d    = sub_a_q;
        sub_b_d    = sub_b_q;
        sub_idx_d  = sub_idx_q;
        sub_last_d = sub_last_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                state_d    = ISSUE;
                idx_d      = 2'd0;
                ae_d       = a_e;
                ao_d       = a_o;
                be_d       = b_e;
                bo_d       = b_o;
                sub_a_d    = a_e;
                sub_b_d    = b_e;
                sub_idx_d  = 2'd0;
                sub_last_d = 1'b0;
            end
        end else if (sub_ready) begin
            if (idx_q == 2'd3) begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end else begin
                idx_d      = idx_q + 2'd1;
                sub_a_d    = idx_d[1] ? ao_q : ae_q;
                sub_b_d    = idx_d[0] ? bo_q : be_q;
                sub_idx_d  = idx_d;
                sub_last_d = idx_d == 2'd3;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ae_q       <= '0;
            ao_q       <= '0;
            be_q       <= '0;
            bo_q       <= '0;
            sub_a_q    <= '0;
            sub_b_q    <= '0;
            sub_idx_q  <= '0;
            sub_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ae_q       <= ae_d;
            ao_q       <= ao_d;
            be_q       <= be_d;
            bo_q       <= bo_d;
            sub_a_q    <= sub_a_d;
            sub_b_q    <= sub_b_d;
            sub_idx_q  <= sub_idx_d;
            sub_last_q <= sub_last_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign busy      = state_q == ISSUE;
    assign sub_valid = state_q == ISSUE;
    assign sub_idx   = sub_idx_q;
    assign sub_a     = sub_a_q;
    assign sub_b     = sub_b_q;
    assign sub_last  = sub_last_q;
endmodule

// File: doc/obs_split_sequencer_97bit.md
OBS_SPLIT_SEQUENCER_97BIT -- requirements
Module: obs_split_sequencer_97bit

Interface
REQ-001 The block SHALL have parameter N, default 193, the full operand width in bits; 193 is the only supported value.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand pair is present on a_in/b_in.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port a_in, input, 193 bits: operand A, a GF(2) polynomial with bit i the coefficient of x^i.
REQ-007 The block SHALL have port b_in, input, 193 bits: operand B, with the same encoding as a_in.
REQ-008 The block SHALL have port sub_valid, output, 1 bit: a sub-product request is present.
REQ-009 The block SHALL have port sub_ready, input, 1 bit: the downstream 97-bit multiplier accepts the request.
REQ-010 The block SHALL have port sub_idx, output, 2 bits: the sub-product index 0..3, selecting overlap input 1..4.
REQ-011 The block SHALL have port sub_a, output, 97 bits: the A-half operand of the request.
REQ-012 The block SHALL have port sub_b, output, 97 bits: the B-half operand of the request.
REQ-013 The block SHALL have port sub_last, output, 1 bit: asserted with sub_idx==3.
REQ-014 The block SHALL have port busy, output, 1 bit: the block is in the ISSUE state.

Function
REQ-015 The block SHALL split each operand into an even half and an odd half, both 97 bits wide:
- even half: e[k] = in[2k] for k = 0..96.
- odd half: o[k] = in[2k+1] for k = 0..95.
- o[96] = 0.
REQ-016 The block SHALL implement an FSM with states IDLE and ISSUE.
REQ-017 in_ready SHALL equal (state==IDLE), and busy SHALL equal (state==ISSUE).
REQ-018 On a rising edge with state IDLE and in_valid=1, the block SHALL:
- register the four halves Ae, Ao, Be, Bo;
- set idx=0;
- enter ISSUE.
REQ-019 in_valid=0 in IDLE SHALL leave all state unchanged.
REQ-020 In ISSUE, sub_valid SHALL be 1, and sub_a/sub_b SHALL be driven by idx as follows:
- idx 0: Ae, Be;
- idx 1: Ae, Bo;
- idx 2: Ao, Be;
- idx 3: Ao, Bo.
REQ-021 The index order in REQ-020 SHALL match the overlap combiner inputs: in1 = AeBe, in2 = AeBo, in3 = AoBe, in4 = AoBo.
REQ-022 sub_a, sub_b, sub_idx and sub_last SHALL be derived only from registered state; there SHALL be no combinational path from a_in/b_in to them.
REQ-023 While sub_valid=1 and sub_ready=0, sub_idx, sub_a, sub_b and sub_last SHALL hold stable.
REQ-024 A handshake (sub_valid & sub_ready) at idx<3 SHALL increment idx by 1 on the next edge.
REQ-025 A handshake at idx==3 SHALL return the FSM to IDLE, and idx SHALL wrap to 0.
REQ-026 Exactly four sub-requests SHALL be issued per accepted operand pair, in order 0,1,2,3, with no skips or repeats.
REQ-027 Latency SHALL be one cycle from the accept edge to the first sub_valid; minimum throughput SHALL be one operand pair per 5 cycles.
REQ-028 in_valid asserted during ISSUE SHALL be ignored; the captured operands SHALL NOT change until the next IDLE accept.
REQ-029 sub_valid SHALL be 0 in IDLE, and sub_a, sub_b, sub_idx and sub_last SHALL then hold their last values.
REQ-030 Simultaneous events SHALL be resolved as follows:
- the final handshake (idx 3) and in_valid in the same cycle: the FSM goes to IDLE and does not accept that cycle;
- the pair is accepted on the following edge if in_valid is still high.

Reset
REQ-031 While rst_n=0, the block SHALL be in state IDLE with idx=0 and the Ae/Ao/Be/Bo registers at 0.
REQ-032 The output reset values SHALL be:
- sub_valid = 0;
- sub_idx = 0;
- sub_a = 0;
- sub_b = 0;
- sub_last = 0;
- busy = 0;
- in_ready = 1.
REQ-033 Reset assertion mid-ISSUE SHALL abort the sequence immediately; no further sub-requests for that operand pair SHALL be issued after release.

Verification
REQ-034 Basic sequence: a_in=1, b_in=1, sub_ready=1 -> four requests, one per cycle:
- idx0: sub_a=1, sub_b=1;
- idx1: sub_a=1, sub_b=0;
- idx2: sub_a=0, sub_b=1;
- idx3: sub_a=0, sub_b=0, sub_last=1;
- then in_ready=1.
REQ-035 Bit mapping:
- a_in = 2^1 gives Ao = 1;
- a_in = 2^191 gives Ao[95] = 1;
- a_in = 2^192 gives Ae[96] = 1 and Ao[96] = 0.
REQ-036 Backpressure: sub_ready held 0 for 3 cycles at idx1 -> idx1 payload stable for those 3 cycles; idx2 follows the first handshake.
REQ-037 Busy ignore: a second in_valid pulse with different operands during ISSUE -> payloads unchanged and exactly 4 requests issued.
REQ-038 Reset mid-operation: rst_n=0 at idx2 -> sub_valid=0 within the same cycle; after release, in_ready=1 and no idx3 request appears.
REQ-039 Product check: random A, B -> overlap-combining the 4 carry-less sub-products gives the reference 385-bit carry-less product A*B.
